// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter. The one-hot grant is registered, and an optional
// hold mode lets the current holder keep the grant for up to MAX_HOLD consecutive cycles.
module rr_arbiter_param #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 4,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hold_mode,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SUM_W = IDX_W + 1;
    localparam int HC_W  = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  MAX_HOLD_C = HC_W'(MAX_HOLD);
    localparam logic [SUM_W-1:0] NUM_REQ_S  = SUM_W'(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic               valid_reg, valid_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;
    logic [NUM_REQ-1:0] search_onehot;
    logic [IDX_W-1:0]   search_idx;
    logic               search_hit;
    logic               hold_ok;

    // Slot gi of the rotated view corresponds to requester (ptr+1+gi) mod NUM_REQ.
    // ptr+1+gi never exceeds 2*NUM_REQ-1, so a single conditional subtract wraps it.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            assign sum          = SUM_W'(ptr_reg) + SUM_W'(gi + 1);
            assign cand_idx[gi] = (sum >= NUM_REQ_S) ? IDX_W'(sum - NUM_REQ_S) : IDX_W'(sum);
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // The lowest set slot of the rotated view is the first requester after ptr.
    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                search_hit = 1'b1;
                search_idx = cand_idx[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign search_onehot[gi] = (search_idx == IDX_W'(gi));
        end
    endgenerate

    assign hold_ok = hold_mode && valid_reg && req[idx_reg] && (hold_cnt_reg < MAX_HOLD_C);

    always_comb begin
        grant_next    = grant_reg;
        valid_next    = valid_reg;
        idx_next      = idx_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        if (en) begin
            if (hold_ok) begin
                hold_cnt_next = hold_cnt_reg + HC_W'(1);
            end else if (search_hit) begin
                // A lone requester wins the search again and restarts its hold count.
                grant_next    = search_onehot;
                valid_next    = 1'b1;
                idx_next      = search_idx;
                ptr_next      = search_idx;
                hold_cnt_next = HC_W'(1);
            end else begin
                // Idle: clear the outputs but keep ptr so that fairness survives the gap.
                grant_next    = '0;
                valid_next    = 1'b0;
                idx_next      = '0;
                hold_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            idx_reg      <= '0;
            ptr_reg      <= PTR_RST;
            hold_cnt_reg <= '0;
        end else begin
            grant_reg    <= grant_next;
            valid_reg    <= valid_next;
            idx_reg      <= idx_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_valid = valid_reg;
    assign grant_idx   = idx_reg;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Bench for rr_arbiter_param: a 4-way and a 5-way instance (both with MAX_HOLD=3) are
// checked against a spec-level round-robin model, with a per-cycle invariant monitor.
module tb_rr_arbiter_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       hold_mode = 1'b0;
    logic [3:0] req4 = '0;
    logic [4:0] req5 = '0;
    logic [3:0] g4;
    logic       gv4;
    logic [1:0] idx4;
    logic [4:0] g5;
    logic       gv5;
    logic [2:0] idx5;

    int checks = 0;
    int errors = 0;

    int m4_ptr, m4_cnt, m4_idx;
    bit m4_v;
    int m5_ptr, m5_cnt, m5_idx;
    bit m5_v;

    always #5 clk = ~clk;

    rr_arbiter_param #(.NUM_REQ(4), .MAX_HOLD(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .hold_mode(hold_mode),
        .req(req4), .grant(g4), .grant_valid(gv4), .grant_idx(idx4)
    );

    rr_arbiter_param #(.NUM_REQ(5), .MAX_HOLD(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .hold_mode(hold_mode),
        .req(req5), .grant(g5), .grant_valid(gv5), .grant_idx(idx5)
    );

    // Reference: holder keeps the grant while it is in hold mode, still requesting and
    // under MAX_HOLD; otherwise the first requester after the last winner takes it.
    task automatic model_step(input int n, input int mh, input int rq, input bit hm,
                              input bit e, inout int ptr, inout int cnt, inout int gidx,
                              inout bit gv);
        bit found;
        if (!e) return;
        if (hm && gv && rq[gidx] && cnt < mh) begin
            cnt++;
            return;
        end
        found = 1'b0;
        for (int o = 1; o <= n; o++) begin
            int k;
            k = (ptr + o) % n;
            if (!found && rq[k]) begin
                found = 1'b1;
                gidx = k;
                ptr = k;
                cnt = 1;
                gv = 1'b1;
            end
        end
        if (!found) begin
            gv = 1'b0;
            gidx = 0;
            cnt = 0;
        end
    endtask

    task automatic model_reset();
        m4_ptr = 3; m4_cnt = 0; m4_idx = 0; m4_v = 1'b0;
        m5_ptr = 4; m5_cnt = 0; m5_idx = 0; m5_v = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(4, 3, int'(req4), hold_mode, en, m4_ptr, m4_cnt, m4_idx, m4_v);
            model_step(5, 3, int'(req5), hold_mode, en, m5_ptr, m5_cnt, m5_idx, m5_v);
        end
        #1;
        $display("t=%0t rst_n=%b en=%b hm=%b req4=%b grant4=%b idx4=%0d req5=%b grant5=%b idx5=%0d",
                 $time, rst_n, en, hold_mode, req4, g4, idx4, req5, g5, idx5);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] exp_g4();
        return m4_v ? 4'(1 << m4_idx) : 4'b0000;
    endfunction

    function automatic logic [4:0] exp_g5();
        return m5_v ? 5'(1 << m5_idx) : 5'b00000;
    endfunction

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(g4) || gv4 !== |g4 || g4[idx4] !== gv4 || (!gv4 && idx4 !== 2'd0)) begin
            errors++;
            $display("FAIL invariant4 grant=%b valid=%b idx=%0d", g4, gv4, idx4);
        end
        checks++;
        if (idx5 > 3'd4 || !$onehot0(g5) || gv5 !== |g5 || g5[idx5] !== gv5 ||
            (!gv5 && idx5 !== 3'd0)) begin
            errors++;
            $display("FAIL invariant5 grant=%b valid=%b idx=%0d", g5, gv5, idx5);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; hold_mode = 1'b0; req4 = 4'b1111; req5 = 5'b11111;
        model_reset();
        #3;
        checks++;
        if (g4 !== 4'b0000 || gv4 !== 1'b0 || idx4 !== 2'd0) begin
            errors++;
            $display("FAIL reset_async got grant=%b valid=%b idx=%0d want 0000/0/0", g4, gv4, idx4);
        end
        tick();
        tick();
        checks++;
        if (g4 !== 4'b0000 || g5 !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold got grant4=%b grant5=%b want zeros", g4, g5);
        end
        req4 = 4'b0000; req5 = 5'b00000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (g4 !== 4'b0000 || gv4 !== 1'b0 || idx4 !== 2'd0 || g5 !== 5'b00000) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got grant=%b valid=%b idx=%0d want 0000/0/0",
                         i, g4, gv4, idx4);
            end
        end
    endtask

    task automatic test_rotate();
        logic [3:0] want [8];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        en = 1'b1; hold_mode = 1'b0; req4 = 4'b1111; req5 = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (g4 !== want[i] || g4 !== exp_g4()) begin
                errors++;
                $display("FAIL rotate4 cyc=%0d got %b want %b", i, g4, want[i]);
            end
            checks++;
            if (idx5 !== 3'(i % 5) || g5 !== exp_g5()) begin
                errors++;
                $display("FAIL rotate5 cyc=%0d got idx=%0d want %0d", i, idx5, i % 5);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] want [9];
        want = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100,
                 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        hold_mode = 1'b1; req4 = 4'b0101; req5 = 5'b00101;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (g4 !== want[i] || g4 !== exp_g4()) begin
                errors++;
                $display("FAIL hold4 cyc=%0d got %b want %b", i, g4, want[i]);
            end
            checks++;
            if (g5 !== exp_g5()) begin
                errors++;
                $display("FAIL hold5 cyc=%0d got %b want %b", i, g5, exp_g5());
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] want [4];
        want = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        do_reset();
        hold_mode = 1'b1; req4 = 4'b1111; req5 = 5'b11111;
        tick();
        checks++;
        if (g4 !== 4'b0001) begin
            errors++;
            $display("FAIL drop_first got %b want 0001", g4);
        end
        req4 = 4'b1110; req5 = 5'b11110;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (g4 !== want[i] || g5 !== exp_g5()) begin
                errors++;
                $display("FAIL drop_move cyc=%0d got %b want %b", i, g4, want[i]);
            end
        end
        req4 = 4'b0010; req5 = 5'b00010;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (g4 !== 4'b0010 || idx4 !== 2'd1 || g5 !== 5'b00010) begin
                errors++;
                $display("FAIL lone_hold cyc=%0d got %b/%b want 0010/00010", i, g4, g5);
            end
        end
    endtask

    task automatic test_ptr_idle();
        logic [3:0] want [3];
        want = '{4'b0001, 4'b0010, 4'b0100};
        do_reset();
        hold_mode = 1'b0; req4 = 4'b1111; req5 = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (g4 !== want[i]) begin
                errors++;
                $display("FAIL ptr_lead cyc=%0d got %b want %b", i, g4, want[i]);
            end
        end
        req4 = 4'b0000; req5 = 5'b00000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (g4 !== 4'b0000 || gv4 !== 1'b0 || idx4 !== 2'd0) begin
                errors++;
                $display("FAIL ptr_idle cyc=%0d got %b want 0000", i, g4);
            end
        end
        req4 = 4'b1111; req5 = 5'b11111;
        tick();
        checks++;
        if (g4 !== 4'b1000 || g5 !== exp_g5()) begin
            errors++;
            $display("FAIL ptr_resume got %b want 1000", g4);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req4 = 4'($urandom); req5 = 5'($urandom);
            tick();
            checks++;
            if (g4 !== 4'b1000 || idx4 !== 2'd3 || gv4 !== 1'b1 || g5 !== exp_g5()) begin
                errors++;
                $display("FAIL en_freeze cyc=%0d got %b idx=%0d want 1000 idx=3", i, g4, idx4);
            end
        end
        en = 1'b1; req4 = 4'b1111; req5 = 5'b11111;
        tick();
        checks++;
        if (g4 !== 4'b0001 || g5 !== exp_g5()) begin
            errors++;
            $display("FAIL en_resume got %b want 0001", g4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        hold_mode = 1'b0; req4 = 4'b1111; req5 = 5'b11111;
        tick();
        tick();
        checks++;
        if (g4 !== 4'b0010) begin
            errors++;
            $display("FAIL areset_pre got %b want 0010", g4);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (g4 !== 4'b0000 || gv4 !== 1'b0 || idx4 !== 2'd0 || g5 !== 5'b00000) begin
            errors++;
            $display("FAIL areset_clear got grant=%b valid=%b idx=%0d want 0000/0/0", g4, gv4, idx4);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (g4 !== 4'b0001 || g5 !== 5'b00001) begin
            errors++;
            $display("FAIL areset_first got %b/%b want 0001/00001", g4, g5);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) hold_mode = ~hold_mode;
            if ($urandom_range(0, 3) != 0) begin
                req4 = 4'($urandom);
                req5 = 5'($urandom);
            end
            tick();
            checks++;
            if (g4 !== exp_g4() || idx4 !== 2'(m4_idx) || gv4 !== m4_v) begin
                errors++;
                $display("FAIL random4 cyc=%0d got %b idx=%0d want %b idx=%0d",
                         i, g4, idx4, exp_g4(), m4_idx);
            end
            checks++;
            if (g5 !== exp_g5() || idx5 !== 3'(m5_idx) || gv5 !== m5_v) begin
                errors++;
                $display("FAIL random5 cyc=%0d got %b idx=%0d want %b idx=%0d",
                         i, g5, idx5, exp_g5(), m5_idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_hold();
        test_drop();
        test_ptr_idle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
